// File: rtl/imem_loader.sv
// imem_loader: program loader for the 256 x 32 instruction memory.
//
// Accepts a byte stream over a valid/ready handshake, packs every DATA_W/8
// bytes into one big-endian instruction word (first byte in the MSB) and
// writes the words to consecutive addresses starting at base_addr. Addresses
// wrap modulo 2^ADDR_W.
//
// Optional feature, compile-time macro IMEM_LOADER_CKSUM_EN:
//   When defined, an 8-bit running sum of the data bytes is kept. After the
//   last word, one extra checksum byte is accepted. err is raised during the
//   done pulse if (sum + checksum) mod 256 != 0. When undefined, no extra
//   byte is taken and err is tied to 0.
//
// Ports:
//   clk         in   system clock, rising edge
//   nreset      in   asynchronous active-low reset
//   start       in   one-cycle load request, honoured only when idle
//   base_addr   in   first word address, latched on start
//   word_count  in   number of words (clamped to 2^ADDR_W), latched on start
//   byte_in     in   stream byte
//   byte_valid  in   byte_in is valid
//   byte_ready  out  loader accepts byte_in this cycle (state-only decode)
//   mem_we      out  memory write enable, one cycle per word
//   mem_waddr   out  registered write address
//   mem_wdata   out  registered write data
//   busy        out  load in progress
//   done        out  one-cycle end-of-load pulse
//   err         out  checksum error, meaningful only while done=1

module imem_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 9
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int BYTES     = DATA_W / 8;
    localparam int IDX_W     = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int MAX_WORDS = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
`ifdef IMEM_LOADER_CKSUM_EN
        S_CKSUM,
`endif
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  written_q, written_d;
    logic [CNT_W-1:0]  clamped_count;
    logic              xfer;

`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0]        sum_q, sum_d;
    logic              err_q, err_d;
    localparam state_t S_LAST = S_CKSUM;
`else
    localparam state_t S_LAST = S_DONE;
`endif

    // Counts above the memory depth would rewrite earlier words, so clamp.
    assign clamped_count = (word_count > CNT_W'(MAX_WORDS)) ? CNT_W'(MAX_WORDS) : word_count;

    // byte_ready is a pure state decode so it never depends on byte_valid.
`ifdef IMEM_LOADER_CKSUM_EN
    assign byte_ready = (state_q == S_COLLECT) || (state_q == S_CKSUM);
    assign err        = (state_q == S_DONE) && err_q;
`else
    assign byte_ready = (state_q == S_COLLECT);
    assign err        = 1'b0;
`endif

    assign xfer      = byte_valid && byte_ready;
    assign busy      = (state_q != S_IDLE);
    assign mem_waddr = addr_q;
    assign mem_wdata = data_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        written_d = written_q;
        mem_we    = 1'b0;
        done      = 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
        sum_d     = sum_q;
        err_d     = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d    = base_addr;
                    cnt_d     = clamped_count;
                    written_d = '0;
                    idx_d     = '0;
`ifdef IMEM_LOADER_CKSUM_EN
                    sum_d     = '0;
                    err_d     = 1'b0;
`endif
                    state_d   = (clamped_count == '0) ? S_LAST : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (xfer) begin
                    // Shifting left puts the first byte of the group in the MSB.
                    data_d = {data_q[DATA_W-9:0], byte_in};
`ifdef IMEM_LOADER_CKSUM_EN
                    sum_d  = sum_q + byte_in;
`endif
                    if (idx_q == IDX_W'(BYTES - 1)) begin
                        idx_d   = '0;
                        state_d = S_WRITE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_WRITE: begin
                mem_we    = 1'b1;
                // addr_q advances only after the write, keeping it stable under mem_we.
                addr_d    = addr_q + ADDR_W'(1);
                written_d = written_q + CNT_W'(1);
                state_d   = (written_d == cnt_q) ? S_LAST : S_COLLECT;
            end
`ifdef IMEM_LOADER_CKSUM_EN
            S_CKSUM: begin
                if (xfer) begin
                    err_d   = ((sum_q + byte_in) != 8'd0);
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            written_q <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
            sum_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            written_q <= written_d;
`ifdef IMEM_LOADER_CKSUM_EN
            sum_q     <= sum_d;
            err_q     <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: self-checking bench for imem_loader.
// A reference model turns each byte stream into the list of expected
// {address, word} writes; a monitor records the writes the loader makes.

module tb_imem_loader;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 9;

    logic              clk = 1'b0;
    logic              nreset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  word_count;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              busy;
    logic              done;
    logic              err;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .nreset     (nreset),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    typedef struct {
        logic [7:0] base;
        logic [8:0] cnt;
        int         gapPct;
        bit         injectStart;
        int         expWrites;
        logic [7:0] expLastAddr;
    } vec_t;

    int         checks    = 0;
    int         failures  = 0;
    int         doneCnt   = 0;
    bit         lastErr   = 1'b0;
    bit         prevDone  = 1'b0;
    logic [39:0] expQ[$];
    logic [39:0] actQ[$];
    logic [7:0]  fixedBytes[$];
    vec_t        vecs[8];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: records every write, counts done pulses, checks handshake rules.
    always @(negedge clk) begin
        if (nreset === 1'b1) begin
            if (prevDone) checkOutput("busy after done", {63'd0, busy}, 64'd0);
            if (mem_we === 1'b1) begin
                actQ.push_back({mem_waddr, mem_wdata});
                checkOutput("ready low in write", {63'd0, byte_ready}, 64'd0);
            end
            if (done === 1'b1) begin
                doneCnt++;
                lastErr = err;
            end
            prevDone = (done === 1'b1);
        end else begin
            prevDone = 1'b0;
        end
    end

    task automatic sendByte(input logic [7:0] b, input int gapPct);
        int guard;
        if ($urandom_range(0, 99) < gapPct) begin
            repeat ($urandom_range(1, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        byte_in    = b;
        byte_valid = 1'b1;
        guard      = 0;
        while (byte_ready !== 1'b1 && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checkOutput("byte accepted", {63'd0, byte_ready}, 64'd1);
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        byte_in    = 8'($urandom_range(0, 255));
    endtask

    task automatic applyStimulus(input logic [7:0] base, input logic [8:0] cnt, input int gapPct,
                                 input bit injectStart, input bit useFixed, input bit badCk);
        int          eff;
        int          doneBefore;
        int          guard;
        logic [7:0]  bytes[$];
        logic [7:0]  sum;
        logic [31:0] w;
        bit          expErr;
        eff = (cnt > 9'd256) ? 256 : int'(cnt);
        bytes = {};
        if (useFixed) bytes = fixedBytes;
        else for (int i = 0; i < eff * 4; i++) bytes.push_back(8'($urandom_range(0, 255)));
        expQ = {};
        actQ = {};
        sum  = 8'd0;
        for (int k = 0; k < eff; k++) begin
            w = 32'(bytes[4*k]) * 32'h0100_0000 + 32'(bytes[4*k+1]) * 32'h0001_0000
              + 32'(bytes[4*k+2]) * 32'h0000_0100 + 32'(bytes[4*k+3]);
            expQ.push_back({8'((int'(base) + k) % 256), w});
        end
        foreach (bytes[i]) sum = sum + bytes[i];
`ifdef IMEM_LOADER_CKSUM_EN
        expErr = badCk;
`else
        expErr = 1'b0;
`endif
        doneBefore = doneCnt;
        base_addr  = base;
        word_count = cnt;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        base_addr  = 8'h77;
        word_count = 9'd1;
        checkOutput("busy after start", {63'd0, busy}, 64'd1);
        for (int i = 0; i < bytes.size(); i++) begin
            sendByte(bytes[i], gapPct);
            if (i % 4 == 3) begin
                checkOutput("we latency", {63'd0, mem_we}, 64'd1);
                checkOutput("waddr at write", {56'd0, mem_waddr}, {56'd0, expQ[i/4][39:32]});
            end
            if (injectStart && i == 5) begin
                start      = 1'b1;
                base_addr  = 8'h55;
                word_count = 9'd7;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        end
`ifdef IMEM_LOADER_CKSUM_EN
        sendByte(8'(8'd0 - sum) + (badCk ? 8'd1 : 8'd0), gapPct);
`endif
        guard = 0;
        while (doneCnt == doneBefore && guard < 40) begin
            @(posedge clk);
            #1;
            guard++;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput("done pulses", 64'(doneCnt - doneBefore), 64'd1);
        checkOutput("err at done", {63'd0, lastErr}, {63'd0, expErr});
        checkOutput("write count", 64'(actQ.size()), 64'(expQ.size()));
        for (int k = 0; k < expQ.size(); k++)
            if (k < actQ.size()) checkOutput($sformatf("write %0d", k), {24'd0, actQ[k]}, {24'd0, expQ[k]});
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        nreset     = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        byte_in    = '0;
        byte_valid = 1'b0;
        #2 nreset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset byte_ready", {63'd0, byte_ready}, 64'd0);
        checkOutput("reset mem_we", {63'd0, mem_we}, 64'd0);
        checkOutput("reset busy", {63'd0, busy}, 64'd0);
        checkOutput("reset done", {63'd0, done}, 64'd0);
        checkOutput("reset err", {63'd0, err}, 64'd0);
        checkOutput("reset waddr", {56'd0, mem_waddr}, 64'd0);
        checkOutput("reset wdata", {32'd0, mem_wdata}, 64'd0);
        nreset = 1'b1;
        @(posedge clk);
        #1;

        // Known bytes, known words.
        fixedBytes = {8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        applyStimulus(8'h10, 9'd2, 0, 1'b0, 1'b1, 1'b0);
        checkOutput("tp word0", {24'd0, (actQ.size() > 0) ? actQ[0] : 40'd0}, {24'd0, 40'h10_1234_5678});
        checkOutput("tp word1", {24'd0, (actQ.size() > 1) ? actQ[1] : 40'd0}, {24'd0, 40'h11_9ABC_DEF0});

`ifndef IMEM_LOADER_CKSUM_EN
        // Zero-length load: done in the cycle after the start edge, no write.
        actQ       = {};
        base_addr  = 8'h20;
        word_count = 9'd0;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("zero done", {63'd0, done}, 64'd1);
        checkOutput("zero we", {63'd0, mem_we}, 64'd0);
        @(posedge clk);
        #1;
        checkOutput("zero done end", {63'd0, done}, 64'd0);
        checkOutput("zero idle", {63'd0, busy}, 64'd0);
        checkOutput("zero no writes", 64'(actQ.size()), 64'd0);
`endif

        // Reset partway through a word: outputs clear at once, nothing written.
        actQ       = {};
        base_addr  = 8'h40;
        word_count = 9'd2;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sendByte(8'h12, 0);
        sendByte(8'h34, 0);
        #2 nreset = 1'b0;
        #1;
        checkOutput("abort busy", {63'd0, busy}, 64'd0);
        checkOutput("abort ready", {63'd0, byte_ready}, 64'd0);
        checkOutput("abort we", {63'd0, mem_we}, 64'd0);
        checkOutput("abort wdata", {32'd0, mem_wdata}, 64'd0);
        checkOutput("abort waddr", {56'd0, mem_waddr}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        nreset = 1'b1;
        checkOutput("abort no writes", 64'(actQ.size()), 64'd0);
        @(posedge clk);
        #1;

        // Checksum vectors (err expected only when the feature is built in).
        fixedBytes = {8'h01, 8'h02, 8'h03, 8'h04};
        applyStimulus(8'h30, 9'd1, 0, 1'b0, 1'b1, 1'b0);
        applyStimulus(8'h31, 9'd1, 0, 1'b0, 1'b1, 1'b1);
        checkOutput("ck word kept", {24'd0, (actQ.size() > 0) ? actQ[0] : 40'd0}, {24'd0, 40'h31_0102_0304});

        vecs[0] = '{8'h10, 9'd2,   0,  1'b0, 2,   8'h11};
        vecs[1] = '{8'hFF, 9'd2,   0,  1'b0, 2,   8'h00};
        vecs[2] = '{8'h20, 9'd3,   40, 1'b1, 3,   8'h22};
        vecs[3] = '{8'h80, 9'd5,   30, 1'b0, 5,   8'h84};
        vecs[4] = '{8'h05, 9'd1,   50, 1'b0, 1,   8'h05};
        vecs[5] = '{8'h44, 9'd0,   0,  1'b0, 0,   8'h00};
        vecs[6] = '{8'hF0, 9'd256, 0,  1'b0, 256, 8'hEF};
        vecs[7] = '{8'h00, 9'd300, 10, 1'b0, 256, 8'hFF};
        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v].base, vecs[v].cnt, vecs[v].gapPct, vecs[v].injectStart, 1'b0, 1'b0);
            checkOutput($sformatf("vec %0d writes", v), 64'(actQ.size()), 64'(vecs[v].expWrites));
            if (vecs[v].expWrites > 0)
                checkOutput($sformatf("vec %0d last addr", v),
                            {56'd0, (actQ.size() > 0) ? actQ[actQ.size()-1][39:32] : 8'd0},
                            {56'd0, vecs[v].expLastAddr});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
